// File: rtl/ahb_mtx_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package     : ahb_mtx_pkg                                                  |
// | Description : Shared AHB encodings for the bus matrix: HTRANS and HBURST   |
// |               codes plus burst_beats(), which returns the number of beats  |
// |               in a fixed-length burst (1 for SINGLE and undefined INCR).   |
// | Ports       : none (package)                                               |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
package ahb_mtx_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [2:0] HBURST_SINGLE = 3'd0;
  localparam logic [2:0] HBURST_INCR   = 3'd1;
  localparam logic [2:0] HBURST_WRAP4  = 3'd2;
  localparam logic [2:0] HBURST_INCR4  = 3'd3;
  localparam logic [2:0] HBURST_WRAP8  = 3'd4;
  localparam logic [2:0] HBURST_INCR8  = 3'd5;
  localparam logic [2:0] HBURST_WRAP16 = 3'd6;
  localparam logic [2:0] HBURST_INCR16 = 3'd7;

  // Undefined-length INCR reports 1 beat so it never triggers a burst hold.
  function automatic logic [4:0] burst_beats(input logic [2:0] hburst);
    logic [4:0] beats;
    case (hburst)
      HBURST_WRAP4,  HBURST_INCR4:  beats = 5'd4;
      HBURST_WRAP8,  HBURST_INCR8:  beats = 5'd8;
      HBURST_WRAP16, HBURST_INCR16: beats = 5'd16;
      default:                      beats = 5'd1;
    endcase
    return beats;
  endfunction

endpackage
`default_nettype wire

// File: rtl/ahb_mtx_rr_pick.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : ahb_mtx_rr_pick                                              |
// | Description : Rotating priority encoder. Fixed mode returns the lowest set |
// |               request index; round-robin mode returns the first set index  |
// |               searching upward from i_base+1 with wrap-around.             |
// | Ports       : i_req     request vector                                     |
// |               i_base    last granted index (round-robin reference)         |
// |               i_rr_mode 1 = round-robin, 0 = fixed priority                |
// |               o_winner  selected index                                     |
// |               o_valid   at least one request present                       |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module ahb_mtx_rr_pick
  import ahb_mtx_pkg::*;
#(
  parameter int NUM_PORTS = 4,
  parameter int PORT_W    = 2
) (
  input  logic [NUM_PORTS-1:0] i_req,
  input  logic [PORT_W-1:0]    i_base,
  input  logic                 i_rr_mode,
  output logic [PORT_W-1:0]    o_winner,
  output logic                 o_valid
);

  int                w_start;
  logic [PORT_W-1:0] w_idx;

  // Walk the rotated order from its far end back to its start so the last
  // hit written is the first request in search order.
  always_comb begin
    o_winner = '0;
    o_valid  = 1'b0;
    w_idx    = '0;
    w_start  = i_rr_mode ? ((int'(i_base) + 1) % NUM_PORTS) : 0;
    for (int i = NUM_PORTS - 1; i >= 0; i--) begin
      w_idx = PORT_W'((w_start + i) % NUM_PORTS);
      if (i_req[w_idx]) begin
        o_winner = w_idx;
        o_valid  = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/ahb_mtx_out_arb_n.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : ahb_mtx_out_arb_n                                            |
// | Description : Output-stage arbiter for one slave port of the AHB matrix.   |
// |               Chooses the input stage owning the address phase, in fixed   |
// |               or round-robin priority, holding the grant across locked     |
// |               sequences and fixed-length bursts.                           |
// | Ports       : HCLK, HRESET      clock, synchronous active-high reset       |
// |               req_port          per-input-stage requests                   |
// |               HREADYM           slave ready; state advances only when high |
// |               HSELM/HTRANSM/HBURSTM/HMASTLOCKM  current owner's transfer   |
// |               addr_in_port      owning input stage (registered)            |
// |               no_port           no input stage selected (registered)       |
// |               burst_hold        fixed-length burst in progress             |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module ahb_mtx_out_arb_n
  import ahb_mtx_pkg::*;
#(
  parameter  int NUM_PORTS  = 4,
  parameter  int ARB_MODE   = 0,
  parameter  int BURST_HOLD = 1,
  localparam int PORT_W     = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
  input  logic                 HCLK,
  input  logic                 HRESET,
  input  logic [NUM_PORTS-1:0] req_port,
  input  logic                 HREADYM,
  input  logic                 HSELM,
  input  logic [1:0]           HTRANSM,
  input  logic [2:0]           HBURSTM,
  input  logic                 HMASTLOCKM,
  output logic [PORT_W-1:0]    addr_in_port,
  output logic                 no_port,
  output logic                 burst_hold
);

  logic [3:0]           r_cnt;        // beats still to come in the current burst
  logic [3:0]           w_cnt_nxt;
  logic [4:0]           w_beats;
  logic                 w_active;
  logic                 w_seq_busy;
  logic                 w_opens_burst;
  logic                 w_hold_burst;
  logic                 w_grant;
  logic                 w_switch;
  logic [NUM_PORTS-1:0] w_owner_oh;
  logic [NUM_PORTS-1:0] w_eff_req;
  logic [PORT_W-1:0]    w_winner;
  logic                 w_valid;
  logic [PORT_W-1:0]    w_rr_base;

  assign w_active   = HSELM & (HTRANSM != HTRANS_IDLE);
  // The current owner keeps competing while it still has live transfers.
  assign w_owner_oh = w_active ? (NUM_PORTS'(1) << addr_in_port) : '0;
  assign w_eff_req  = req_port | w_owner_oh;
  assign w_beats    = burst_beats(HBURSTM);
  assign w_seq_busy = (HTRANSM == HTRANS_SEQ) | (HTRANSM == HTRANS_BUSY);

  // The NONSEQ opening a fixed-length burst must also keep the grant,
  // otherwise a higher-priority request would steal the bus before the
  // first SEQ beat and the burst could never complete.
  assign w_opens_burst = w_active & (HTRANSM == HTRANS_NONSEQ) & (w_beats > 5'd1);
  assign w_hold_burst  = (BURST_HOLD != 0) &
                         (((r_cnt != 4'd0) & w_seq_busy) | w_opens_burst);

  assign w_grant  = ~HMASTLOCKM & ~w_hold_burst & w_valid;
  assign w_switch = w_grant & (w_winner != addr_in_port);

  ahb_mtx_rr_pick #(
    .NUM_PORTS (NUM_PORTS),
    .PORT_W    (PORT_W)
  ) u_pick (
    .i_req     (w_eff_req),
    .i_base    (w_rr_base),
    .i_rr_mode (ARB_MODE == 1),
    .o_winner  (w_winner),
    .o_valid   (w_valid)
  );

  generate
    if (ARB_MODE == 1 && NUM_PORTS > 1) begin : g_rr_ptr
      logic [PORT_W-1:0] r_rr_ptr;
      always_ff @(posedge HCLK) begin
        if (HRESET) begin
          r_rr_ptr <= '0;
        end else if (HREADYM && w_grant) begin
          r_rr_ptr <= w_winner;
        end
      end
      assign w_rr_base = r_rr_ptr;
    end else begin : g_no_rr_ptr
      assign w_rr_base = '0;
    end
  endgenerate

  // IDLE or a fresh NONSEQ mid-burst terminates the burst early by
  // clearing or reloading the count.
  always_comb begin
    w_cnt_nxt = r_cnt;
    case (HTRANSM)
      HTRANS_IDLE:   w_cnt_nxt = 4'd0;
      HTRANS_BUSY:   w_cnt_nxt = r_cnt;
      HTRANS_NONSEQ: w_cnt_nxt = w_active ? 4'(w_beats - 5'd1) : 4'd0;
      default:       w_cnt_nxt = (r_cnt != 4'd0) ? (r_cnt - 4'd1) : 4'd0;
    endcase
    if (w_switch || (BURST_HOLD == 0)) begin
      w_cnt_nxt = 4'd0;
    end
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      addr_in_port <= '0;
      no_port      <= 1'b1;
      r_cnt        <= 4'd0;
    end else if (HREADYM) begin
      r_cnt <= w_cnt_nxt;
      if (HMASTLOCKM || w_hold_burst) begin
        no_port <= 1'b0;
      end else if (w_valid) begin
        addr_in_port <= w_winner;
        no_port      <= 1'b0;
      end else begin
        no_port <= ~HSELM;
      end
    end
  end

  assign burst_hold = (r_cnt != 4'd0);

endmodule
`default_nettype wire
